aes_key_schedule_ctrl: RTL and testbench

Sequences AES key expansion, one 32-bit word per clock, for AES-128/192/256 (selected by parameter). Each cycle it drives the shared ShiftWordLeft unit (RotWord) and the SubWord unit with the correct shift size and operands, and tracks Rcon. Results are written into an internal round-key store. The encryption/decryption round datapath reads round keys from that store by round index.

---
 rtl/aes_pkg.sv | 50 +++++
 rtl/aes_key_schedule_ctrl_key_word_gen.sv | 66 ++++++
 rtl/aes_key_schedule_ctrl.sv | 96 +++++++++
 tb/tb_aes_key_schedule_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES key-schedule definitions.
//   - RCON_INIT / XTIME_POLY / NB constants
//   - nr_of(nk): number of rounds for a key of nk 32-bit words
//   - state_t: key-schedule FSM states
//   - kwMode_t: per-word transform selector for key_word_gen
//   - xtime / gmul / sbox: GF(2^8) helpers; sbox is computed as the
//     multiplicative inverse followed by the FIPS-197 affine transform
package aes_pkg;

    localparam logic [7:0] RCON_INIT  = 8'h01;
    localparam logic [7:0] XTIME_POLY = 8'h1b;
    localparam int         NB         = 4;

    typedef enum logic [1:0] {IDLE, GEN, DONE} state_t;
    typedef enum logic [1:0] {ROT_SUB, SUB_ONLY, PASS} kwMode_t;

    function automatic int nr_of(input int nk);
        return nk + 6;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return a[7] ? ({a[6:0], 1'b0} ^ XTIME_POLY) : {a[6:0], 1'b0};
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // a^254 == a^-1 in GF(2^8); 0 maps to 0 naturally.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] r, p, s;
        r = 8'h01;
        p = a;
        for (int k = 1; k < 8; k++) begin
            p = gmul(p, p);
            r = gmul(r, p);
        end
        s = r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]}
              ^ {r[3:0], r[7:4]} ^ 8'h63;
        return s;
    endfunction

endpackage

// File: rtl/aes_key_schedule_ctrl_key_word_gen.sv
// Key-word datapath pieces.
//   ShiftWordLeft: rotate a 32-bit word left by `shift` bytes
//     wordIn [31:0], shift [1:0] -> wordOut [31:0]
//   SubWord: S-box applied to each byte of a word
//     wordIn [31:0] -> wordOut [31:0]
//   key_word_gen: combinational next expanded word
//     wPrev = w[i-1], wBack = w[i-NK], rcon, mode -> wNext = w[i]
module ShiftWordLeft (
    input  logic [31:0] wordIn,
    input  logic [1:0]  shift,
    output logic [31:0] wordOut
);
    always_comb begin
        case (shift)
            2'd1:    wordOut = {wordIn[23:0], wordIn[31:24]};
            2'd2:    wordOut = {wordIn[15:0], wordIn[31:16]};
            2'd3:    wordOut = {wordIn[7:0],  wordIn[31:8]};
            default: wordOut = wordIn;
        endcase
    end
endmodule

module SubWord
    import aes_pkg::*;
(
    input  logic [31:0] wordIn,
    output logic [31:0] wordOut
);
    for (genvar b = 0; b < 4; b++) begin : gByte
        assign wordOut[8*b +: 8] = sbox(wordIn[8*b +: 8]);
    end
endmodule

module key_word_gen
    import aes_pkg::*;
(
    input  logic [31:0] wPrev,
    input  logic [31:0] wBack,
    input  logic [7:0]  rcon,
    input  kwMode_t     mode,
    output logic [31:0] wNext
);
    logic [31:0] shifted;
    logic [31:0] subbed;
    logic [31:0] temp;

    ShiftWordLeft uShift (
        .wordIn (wPrev),
        .shift  ((mode == ROT_SUB) ? 2'd1 : 2'd0),
        .wordOut(shifted)
    );

    SubWord uSub (
        .wordIn (shifted),
        .wordOut(subbed)
    );

    always_comb begin
        case (mode)
            ROT_SUB:  temp = subbed ^ {rcon, 24'h0};
            SUB_ONLY: temp = subbed;
            default:  temp = wPrev;
        endcase
        wNext = wBack ^ temp;
    end
endmodule

// File: rtl/aes_key_schedule_ctrl.sv
// AES key expansion controller, one 32-bit word per clock.
//   clk, reset        : clock, synchronous active-high reset
//   start, key_in     : begin expansion of key_in (ignored while busy)
//   busy, key_ready   : generation in progress / all NW words valid
//   rd_round, rd_key  : combinational round-key read, 0 beyond NR
module aes_key_schedule_ctrl
    import aes_pkg::*;
#(
    parameter int NK = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [32*NK-1:0] key_in,
    output logic            busy,
    output logic            key_ready,
    input  logic [3:0]      rd_round,
    output logic [127:0]    rd_key
);
    localparam int NR = nr_of(NK);
    localparam int NW = NB * (NR + 1);

    if (NK != 4 && NK != 6 && NK != 8) begin : gBadNk
        $error("aes_key_schedule_ctrl: NK must be 4, 6 or 8");
    end

    state_t            state;
    logic [NW-1:0][31:0] w;
    logic [5:0]        wIdx;     // next word to generate
    logic [2:0]        modCnt;   // wIdx mod NK
    logic [7:0]        rcon;
    kwMode_t           mode;
    logic [31:0]       wNext;

    always_comb begin
        mode = PASS;
        if (modCnt == 3'd0)                 mode = ROT_SUB;
        else if (NK == 8 && modCnt == 3'd4) mode = SUB_ONLY;
    end

    key_word_gen uGen (
        .wPrev(w[wIdx - 6'd1]),
        .wBack(w[wIdx - 6'(NK)]),
        .rcon (rcon),
        .mode (mode),
        .wNext(wNext)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            w         <= '0;
            wIdx      <= '0;
            modCnt    <= '0;
            rcon      <= RCON_INIT;
            busy      <= 1'b0;
            key_ready <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        for (int k = 0; k < NK; k++)
                            w[k] <= key_in[32*(NK-k)-1 -: 32];
                        wIdx      <= 6'(NK);
                        modCnt    <= '0;
                        rcon      <= RCON_INIT;
                        key_ready <= 1'b0;
                        busy      <= 1'b1;
                        state     <= GEN;
                    end
                end
                GEN: begin
                    w[wIdx] <= wNext;
                    wIdx    <= wIdx + 6'd1;
                    modCnt  <= (modCnt == 3'(NK-1)) ? 3'd0 : modCnt + 3'd1;
                    if (mode == ROT_SUB) rcon <= xtime(rcon);
                    if (wIdx == 6'(NW-1)) begin
                        busy      <= 1'b0;
                        key_ready <= 1'b1;
                        state     <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic [5:0] base;
    always_comb begin
        base   = {rd_round, 2'b00};
        rd_key = '0;
        if (rd_round <= 4'(NR))
            rd_key = {w[base], w[base + 6'd1], w[base + 6'd2], w[base + 6'd3]};
    end

endmodule

// File: tb/tb_aes_key_schedule_ctrl.sv
module tb_aes_key_schedule_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start4 = 1'b0, start6 = 1'b0, start8 = 1'b0;
    logic [127:0] keyIn4 = '0;
    logic [191:0] keyIn6 = '0;
    logic [255:0] keyIn8 = '0;
    logic busy4, busy6, busy8, ready4, ready6, ready8;
    logic [3:0] rdRound = '0;
    logic [127:0] rdKey4, rdKey6, rdKey8;

    int nChecks = 0;
    int nFail = 0;

    always #5 clk = ~clk;

    aes_key_schedule_ctrl #(.NK(4)) dut4 (.clk(clk), .reset(reset), .start(start4),
        .key_in(keyIn4), .busy(busy4), .key_ready(ready4), .rd_round(rdRound), .rd_key(rdKey4));
    aes_key_schedule_ctrl #(.NK(6)) dut6 (.clk(clk), .reset(reset), .start(start6),
        .key_in(keyIn6), .busy(busy6), .key_ready(ready6), .rd_round(rdRound), .rd_key(rdKey6));
    aes_key_schedule_ctrl #(.NK(8)) dut8 (.clk(clk), .reset(reset), .start(start8),
        .key_in(keyIn8), .busy(busy8), .key_ready(ready8), .rd_round(rdRound), .rd_key(rdKey8));

    localparam logic [127:0] KEY_A1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [191:0] KEY_A2 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    localparam logic [255:0] KEY_A3 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] A1_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    typedef struct {
        int           unit;   // 0:NK4 1:NK6 2:NK8
        logic [3:0]   round;
        int           lane;   // -1 full key, else word 0..3 within the round key
        logic [127:0] exp;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Count busy cycles and the cycle key_ready is first seen on NK=4,
    // starting right after the start edge. Optional start re-pulses with
    // a different key at GEN cycles p1/p2.
    task automatic run4(input int p1, input int p2, output int bc, output int rdy);
        bc = 0;
        rdy = 0;
        for (int c = 1; c <= 100; c++) begin
            if (c == p1 || c == p2) begin
                keyIn4 = 128'hffeeddccbbaa99887766554433221100;
                start4 = 1'b1;
            end
            @(negedge clk);
            if (busy4) bc++;
            if (ready4 && rdy == 0) rdy = c;
            tick();
            start4 = 1'b0;
            if (rdy != 0) break;
        end
    endtask

    initial begin
        int bc, rdy;
        int bc4, bc6, bc8, r4, r6, r8;
        logic [127:0] act;

        vecs[0]  = '{0, 4'd0,  -1, KEY_A1};
        vecs[1]  = '{0, 4'd1,   0, 128'ha0fafe17};
        vecs[2]  = '{0, 4'd10, -1, A1_R10};
        vecs[3]  = '{0, 4'd11, -1, 128'h0};
        vecs[4]  = '{0, 4'd15, -1, 128'h0};
        vecs[5]  = '{1, 4'd0,  -1, 128'h8e73b0f7da0e6452c810f32b809079e5};
        vecs[6]  = '{1, 4'd1,   2, 128'hfe0c91f7};
        vecs[7]  = '{1, 4'd12, -1, 128'he98ba06f448c773c8ecc720401002202};
        vecs[8]  = '{1, 4'd13, -1, 128'h0};
        vecs[9]  = '{2, 4'd0,  -1, 128'h603deb1015ca71be2b73aef0857d7781};
        vecs[10] = '{2, 4'd1,  -1, 128'h1f352c073b6108d72d9810a30914dff4};
        vecs[11] = '{2, 4'd2,   0, 128'h9ba35411};
        vecs[12] = '{2, 4'd3,   0, 128'ha8b09c1a};
        vecs[13] = '{2, 4'd14,  3, 128'h706c631e};
        vecs[14] = '{2, 4'd15, -1, 128'h0};

        // Reset state
        repeat (2) tick();
        reset = 1'b0;
        @(negedge clk);
        chk("reset_busy", {125'h0, busy4, busy6, busy8}, 128'h0);
        chk("reset_ready", {125'h0, ready4, ready6, ready8}, 128'h0);
        chk("reset_store", rdKey4 | rdKey6 | rdKey8, 128'h0);

        // Start all three key sizes together
        tick();
        keyIn4 = KEY_A1; keyIn6 = KEY_A2; keyIn8 = KEY_A3;
        start4 = 1'b1; start6 = 1'b1; start8 = 1'b1;
        tick();
        start4 = 1'b0; start6 = 1'b0; start8 = 1'b0;
        keyIn4 = '0; keyIn6 = '0; keyIn8 = '0;
        bc4 = 0; bc6 = 0; bc8 = 0; r4 = 0; r6 = 0; r8 = 0;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (busy4) bc4++;
            if (busy6) bc6++;
            if (busy8) bc8++;
            if (ready4 && r4 == 0) r4 = c;
            if (ready6 && r6 == 0) r6 = c;
            if (ready8 && r8 == 0) r8 = c;
            tick();
            if (r4 != 0 && r6 != 0 && r8 != 0) break;
        end
        chk("busy_len_nk4", 128'(bc4), 128'd40);
        chk("busy_len_nk6", 128'(bc6), 128'd46);
        chk("busy_len_nk8", 128'(bc8), 128'd52);
        chk("ready_cycle_nk4", 128'(r4), 128'd41);
        chk("ready_cycle_nk6", 128'(r6), 128'd47);
        chk("ready_cycle_nk8", 128'(r8), 128'd53);

        // Table-driven round-key reads
        for (int v = 0; v < 15; v++) begin
            rdRound = vecs[v].round;
            #1;
            act = (vecs[v].unit == 0) ? rdKey4 : (vecs[v].unit == 1) ? rdKey6 : rdKey8;
            if (vecs[v].lane >= 0)
                act = (act >> (32 * (3 - vecs[v].lane))) & 128'hffffffff;
            chk($sformatf("vec%0d_u%0d_r%0d", v, vecs[v].unit, vecs[v].round), act, vecs[v].exp);
        end

        // Start re-pulsed during GEN must be ignored
        keyIn4 = KEY_A1;
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        run4(5, 20, bc, rdy);
        chk("repulse_busy_len", 128'(bc), 128'd40);
        chk("repulse_ready", 128'(rdy), 128'd41);
        rdRound = 4'd10;
        #1;
        chk("repulse_round10", rdKey4, A1_R10);

        // Reset mid-generation aborts
        keyIn4 = KEY_A1;
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        repeat (20) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        rdRound = 4'd0;
        @(negedge clk);
        chk("midreset_busy", {127'h0, busy4}, 128'h0);
        chk("midreset_ready", {127'h0, ready4}, 128'h0);
        chk("midreset_round0", rdKey4, 128'h0);
        tick();
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        run4(0, 0, bc, rdy);
        rdRound = 4'd10;
        #1;
        chk("after_reset_round10", rdKey4, A1_R10);

        // Reset and start together: reset wins
        reset = 1'b1;
        start4 = 1'b1;
        tick();
        reset = 1'b0;
        start4 = 1'b0;
        @(negedge clk);
        chk("rst_start_busy", {126'h0, busy4, ready4}, 128'h0);
        tick();
        @(negedge clk);
        chk("rst_start_idle", {127'h0, busy4}, 128'h0);

        // Run A.1, then restart from DONE with an all-zero key
        tick();
        keyIn4 = KEY_A1;
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        run4(0, 0, bc, rdy);
        @(negedge clk);
        chk("done_ready_holds", {127'h0, ready4}, 128'h1);
        tick();
        keyIn4 = '0;
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        @(negedge clk);
        chk("restart_ready_drop", {126'h0, ready4, busy4}, 128'h1);
        tick();
        run4(0, 0, bc, rdy);
        chk("zero_key_ready_seen", 128'(rdy != 0), 128'h1);
        rdRound = 4'd1;
        #1;
        chk("zero_key_round1", rdKey4, 128'h62636363626363636263636362636363);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
